// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the data-memory access sequencer and the main control FSM.
// The package holds:
//   - the load/store opcode constants (instruction bits [31:26]),
//   - the sequencer state encoding,
//   - helper functions for opcode classification, byte-enable generation,
//     store-lane replication and misalignment detection.
package mem_access_ctrl_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } mac_state_t;

   function automatic logic is_mem_op(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
         default:             is_mem_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: is_store = 1'b1;
         default:             is_store = 1'b0;
      endcase
   endfunction

   // Halfword lane follows addr[1] only and words ignore the low bits, so a
   // misaligned access (when not trapped) still hits the containing word.
   function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] a);
      case (op)
         OP_LW, OP_SW:          byte_en = 4'b1111;
         OP_LH, OP_LHU, OP_SH:  byte_en = a[1] ? 4'b1100 : 4'b0011;
         OP_LB, OP_LBU, OP_SB:  byte_en = 4'b0001 << a;
         default:               byte_en = 4'b0000;
      endcase
   endfunction

   // Replicate store data so the selected lane carries it regardless of offset.
   function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] wd);
      case (op)
         OP_SB:   store_data = {4{wd[7:0]}};
         OP_SH:   store_data = {2{wd[15:0]}};
         default: store_data = wd;
      endcase
   endfunction

   function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: misaligned = a[0];
         OP_LW, OP_SW:         misaligned = (a != 2'b00);
         default:              misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// load_align
// Purely combinational load lane extraction and extension.
// Ports:
//   opcode  in  6   latched load opcode
//   addr_lo in  2   byte offset of the access
//   raw     in  32  word returned by the data memory
//   result  out 32  lane-extracted, sign/zero-extended load value
module load_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte and halfword lanes from the raw word.
   always_comb begin
      byte_s = 8'h00;
      case (addr_lo)
         2'b00:   byte_s = raw[7:0];
         2'b01:   byte_s = raw[15:8];
         2'b10:   byte_s = raw[23:16];
         2'b11:   byte_s = raw[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_s = raw[31:16];
      end else begin
         half_s = raw[15:0];
      end
   end

   // Extend the selected lane according to the load flavour.
   always_comb begin
      result = raw;
      case (opcode)
         OP_LB:   result = {{24{byte_s[7]}}, byte_s};
         OP_LBU:  result = {24'h000000, byte_s};
         OP_LH:   result = {{16{half_s[15]}}, half_s};
         OP_LHU:  result = {16'h0000, half_s};
         OP_LW:   result = raw;
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multi-cycle data-memory access sequencer. Latches one load/store request
// from the control FSM, drives the memory port under a req/ack handshake and
// returns the aligned, extended load result with a one-cycle done pulse.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses skip
// memory and report err together with done).
// Ports:
//   clk, rst            clock (rising) and async active-high reset
//   start, opcode, addr, wdata_in   request from the control FSM
//   busy, done, rdata_out, err      status/result towards the control FSM
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   memory request side
//   mem_rdata, mem_ack                             memory response side
// All outputs are registered.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata_in,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata_out,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   mac_state_t  state_r;
   mac_state_t  state_nxt_s;
   logic [5:0]  op_r;
   logic [1:0]  addr_lo_r;
   logic        accept_s;
   logic        trap_s;
   logic        finish_s;
   logic        misalign_s;
   logic [31:0] load_val_s;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_s = misaligned(opcode, addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   load_align u_load_align (
      .opcode  (op_r),
      .addr_lo (addr_lo_r),
      .raw     (mem_rdata),
      .result  (load_val_s)
   );

   // Next-state logic; accept_s starts a memory access, trap_s short-cuts to DONE.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      trap_s      = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && is_mem_op(opcode)) begin
               if (misalign_s) begin
                  trap_s      = 1'b1;
                  state_nxt_s = ST_DONE;
               end else begin
                  accept_s    = 1'b1;
                  state_nxt_s = ST_ACCESS;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               finish_s    = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered status outputs derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         mem_req <= 1'b0;
      end else begin
         busy    <= (state_nxt_s != ST_IDLE);
         done    <= (state_nxt_s == ST_DONE);
         err     <= trap_s;
         mem_req <= (state_nxt_s == ST_ACCESS);
      end
   end

   // Request latch: memory-side fields are captured once and held through ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= 6'b000000;
         addr_lo_r <= 2'b00;
         mem_we    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h00000000;
      end else if (accept_s) begin
         op_r      <= opcode;
         addr_lo_r <= addr[1:0];
         mem_we    <= is_store(opcode);
         mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
         mem_be    <= byte_en(opcode, addr[1:0]);
         mem_wdata <= store_data(opcode, wdata_in);
      end else if (finish_s) begin
         mem_we    <= 1'b0;
      end
   end

   // Load result register, updated only when a load completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_out <= 32'h00000000;
      end else if (finish_s && !is_store(op_r)) begin
         rdata_out <= load_val_s;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios with hand-computed values.
module tb_mem_access_ctrl;

   localparam logic [5:0] T_LB  = 6'b100000;
   localparam logic [5:0] T_LH  = 6'b100001;
   localparam logic [5:0] T_LW  = 6'b100011;
   localparam logic [5:0] T_LBU = 6'b100100;
   localparam logic [5:0] T_LHU = 6'b100101;
   localparam logic [5:0] T_SB  = 6'b101000;
   localparam logic [5:0] T_SH  = 6'b101001;
   localparam logic [5:0] T_SW  = 6'b101011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  opcode = 6'b000000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata_in = 32'h0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata_out, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
      .wdata_in(wdata_in), .busy(busy), .done(done), .rdata_out(rdata_out),
      .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a start for one sampling edge; returns 1 time unit after that edge.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
      opcode = op; addr = a; wdata_in = wd; start = 1'b1;
      step();
      start = 1'b0; opcode = 6'b000000;
   endtask

   // One-cycle ack with read data.
   task automatic ack_cycle(input logic [31:0] rd);
      mem_rdata = rd; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      checks++; if ({busy, done, err, mem_req, mem_we} !== 5'b00000) begin errors++; $display("FAIL rst_flags got %b exp 00000", {busy, done, err, mem_req, mem_we}); end
      checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem got %h/%h/%h exp 0", mem_addr, mem_be, mem_wdata); end
      checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata_out); end
      rst = 1'b0;
      step();
      // ack while idle must be ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      step();
      checks++; if ({busy, done, mem_req} !== 3'b000 || rdata_out !== 32'h0) begin errors++; $display("FAIL idle_ack got %b rdata %h exp 000 0", {busy, done, mem_req}, rdata_out); end
   endtask

   task automatic test_sw();
      issue(T_SW, 32'h100, 32'hDEADBEEF);
      checks++; if ({mem_req, mem_we, busy, done} !== 4'b1110) begin errors++; $display("FAIL sw_req got %b exp 1110", {mem_req, mem_we, busy, done}); end
      checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1111) begin errors++; $display("FAIL sw_addr_be got %h/%b exp 00000100/1111", mem_addr, mem_be); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); end
      ack_cycle(32'h0);
      checks++; if ({done, mem_req, err} !== 3'b100) begin errors++; $display("FAIL sw_done got %b exp 100", {done, mem_req, err}); end
      checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rdata_out); end
      step();
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL sw_end got %b exp 00", {done, busy}); end
   endtask

   task automatic test_sb();
      issue(T_SB, 32'h103, 32'h000000A5);
      checks++; if (mem_be !== 4'b1000 || mem_we !== 1'b1) begin errors++; $display("FAIL sb_be got %b we %b exp 1000 1", mem_be, mem_we); end
      checks++; if (mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h100) begin errors++; $display("FAIL sb_data got %h/%h exp a5a5a5a5/00000100", mem_wdata, mem_addr); end
      ack_cycle(32'h0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", done); end
      step();
   endtask

   task automatic test_byte_loads();
      issue(T_LB, 32'h201, 32'h0);
      checks++; if (mem_be !== 4'b0010 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin errors++; $display("FAIL lb_req got %b/%b/%h exp 0010/0/00000200", mem_be, mem_we, mem_addr); end
      ack_cycle(32'h123480FF);
      checks++; if (rdata_out !== 32'hFFFFFF80 || done !== 1'b1) begin errors++; $display("FAIL lb_data got %h done %b exp ffffff80 1", rdata_out, done); end
      step();
      issue(T_LBU, 32'h201, 32'h0);
      ack_cycle(32'h123480FF);
      checks++; if (rdata_out !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", rdata_out); end
      step();
   endtask

   task automatic test_lh_wait();
      int done_cnt;
      done_cnt = 0;
      issue(T_LH, 32'h302, 32'h0);
      // a start during ACCESS (sw here) must not disturb the held request
      start = 1'b1; opcode = T_SW; wdata_in = 32'h11111111;
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_be !== 4'b1100 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300) begin errors++; $display("FAIL lh_hold%0d got %b/%b/%b/%h exp 1100/1/0/00000300", i, mem_be, mem_req, mem_we, mem_addr); end
         if (done) done_cnt++;
         if (i < 3) step();
      end
      start = 1'b0; opcode = 6'b000000;
      ack_cycle(32'h80010000);
      if (done) done_cnt++;
      checks++; if (rdata_out !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", rdata_out); end
      step();
      if (done) done_cnt++;
      step();
      if (done) done_cnt++;
      checks++; if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL lh_done_once got %0d busy %b exp 1 0", done_cnt, busy); end
   endtask

   task automatic test_misaligned();
      logic [31:0] prev;
      prev = rdata_out;
      issue(T_LW, 32'h401, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      checks++; if ({mem_req, done, err} !== 3'b011) begin errors++; $display("FAIL mis_trap got %b exp 011", {mem_req, done, err}); end
      checks++; if (rdata_out !== prev) begin errors++; $display("FAIL mis_rdata got %h exp %h", rdata_out, prev); end
      step();
      checks++; if ({done, err, busy} !== 3'b000) begin errors++; $display("FAIL mis_end got %b exp 000", {done, err, busy}); end
`else
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_be !== 4'b1111) begin errors++; $display("FAIL mis_req got %b/%h/%b exp 1/00000400/1111 prev %h", mem_req, mem_addr, mem_be, prev); end
      ack_cycle(32'h55AA00FF);
      checks++; if ({done, err} !== 2'b10 || rdata_out !== 32'h55AA00FF) begin errors++; $display("FAIL mis_load got %b %h exp 10 55aa00ff", {done, err}, rdata_out); end
      step();
`endif
   endtask

   task automatic test_back_to_back();
      issue(T_SH, 32'h0A2, 32'h1234CAFE);
      checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hCAFECAFE || mem_addr !== 32'h0A0) begin errors++; $display("FAIL sh_req got %b/%h/%h exp 1100/cafecafe/000000a0", mem_be, mem_wdata, mem_addr); end
      ack_cycle(32'h0);
      step();
      issue(T_LHU, 32'h0A0, 32'h0);
      checks++; if (mem_req !== 1'b1 || mem_be !== 4'b0011 || mem_we !== 1'b0) begin errors++; $display("FAIL b2b_req got %b/%b/%b exp 1/0011/0", mem_req, mem_be, mem_we); end
      ack_cycle(32'h77779ABC);
      checks++; if (rdata_out !== 32'h00009ABC || done !== 1'b1) begin errors++; $display("FAIL lhu_data got %h done %b exp 00009abc 1", rdata_out, done); end
      step();
   endtask

   task automatic test_abort();
      int done_cnt;
      done_cnt = 0;
      issue(T_LW, 32'h500, 32'h0);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre got %b exp 1", mem_req); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({mem_req, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_async got %b exp 000", {mem_req, busy, done}); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) done_cnt++;
      end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_nodone got %0d exp 0", done_cnt); end
      issue(6'b000000, 32'h600, 32'h0);
      checks++; if ({busy, mem_req, done} !== 3'b000) begin errors++; $display("FAIL nonmem_start got %b exp 000", {busy, mem_req, done}); end
      step();
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL nonmem_after got %b exp 00", {busy, done}); end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb();
      test_byte_loads();
      test_lh_wait();
      test_misaligned();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
